// File: rtl/bus_pkg.sv
// bus_pkg: state and size encodings shared by the sram-like bus bridges
//   state_t : bridge FSM states (IDLE, WAIT_ADDR, WAIT_DATA, DONE)
//   SIZE_*  : data_size codes for byte, halfword and word transfers
package bus_pkg;
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_ADDR = 2'd1,
      S_WAIT_DATA = 2'd2,
      S_DONE      = 2'd3
   } state_t;
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
endpackage

// File: rtl/wen_to_size.sv
// wen_to_size: byte write-enable to bus transfer size decode
//   wen   : byte write enables, 0000 means read
//   size  : SIZE_B / SIZE_H / SIZE_W, reads and malformed masks give SIZE_W
//   legal : low when wen is not a mask the core is allowed to produce
module wen_to_size
   import bus_pkg::*;
(
   input  logic [3:0] wen,
   output logic [1:0] size,
   output logic       legal
);
   always_comb begin
      size  = SIZE_W;
      legal = 1'b1;
      case (wen)
         4'b0000, 4'b1111:                    size = SIZE_W;
         4'b0011, 4'b1100:                    size = SIZE_H;
         4'b0001, 4'b0010, 4'b0100, 4'b1000:  size = SIZE_B;
         default:                             legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/d_sram_bridge.sv
// d_sram_bridge: core SRAM-style data port to split-transaction sram-like bus
//   core side : data_sram_en/wen/addr/wdata in, data_sram_rdata out,
//               longest_stall in, d_stall out
//   bus side  : data_req/wr/size/addr/wdata out,
//               data_addr_ok/data_ok/rdata in
//   clk, rst (asynchronous, active low)
module d_sram_bridge
   import bus_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          data_sram_en,
   input  logic [3:0]    data_sram_wen,
   input  logic [AW-1:0] data_sram_addr,
   input  logic [DW-1:0] data_sram_wdata,
   output logic [DW-1:0] data_sram_rdata,
   input  logic          longest_stall,
   output logic          d_stall,
   output logic          data_req,
   output logic          data_wr,
   output logic [1:0]    data_size,
   output logic [AW-1:0] data_addr,
   output logic [DW-1:0] data_wdata,
   input  logic          data_addr_ok,
   input  logic          data_data_ok,
   input  logic [DW-1:0] data_rdata
);
   state_t        state, nextState;
   logic [DW-1:0] rdataBuf;
   logic          capture, wenLegal;
   wen_to_size uSize (.wen(data_sram_wen), .size(data_size), .legal(wenLegal));
   // The core holds its request while stalled, so the bus fields are driven straight through.
   assign data_wr         = |data_sram_wen;
   assign data_addr       = data_wr ? data_sram_addr : {data_sram_addr[AW-1:2], 2'b00};
   assign data_wdata      = data_sram_wdata;
   assign d_stall         = data_sram_en & (state != S_DONE);
   assign data_sram_rdata = rdataBuf;
   always_comb begin
      nextState = state;
      data_req  = 1'b0;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            data_req = data_sram_en;
            capture  = data_sram_en & data_addr_ok & data_data_ok;
            if (data_sram_en) nextState = !data_addr_ok ? S_WAIT_ADDR : data_data_ok ? S_DONE : S_WAIT_DATA;
         end
         S_WAIT_ADDR: begin
            data_req = 1'b1;
            capture  = data_addr_ok & data_data_ok;
            if (data_addr_ok) nextState = data_data_ok ? S_DONE : S_WAIT_DATA;
         end
         S_WAIT_DATA: begin
            capture   = data_data_ok;
            nextState = data_data_ok ? S_DONE : S_WAIT_DATA;
         end
         // DONE holds while the rest of the pipeline is frozen so the access is not reissued.
         default: nextState = longest_stall ? S_DONE : S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         rdataBuf <= '0;
      end else begin
         state <= nextState;
         if (capture) rdataBuf <= data_rdata;
      end
   end
   assert property (@(posedge clk) disable iff (!rst) data_sram_en & data_wr |-> wenLegal);
   assert property (@(posedge clk) disable iff (!rst) state == S_WAIT_ADDR |-> data_sram_en);
endmodule

// File: tb/tb_d_sram_bridge.sv
// tb_d_sram_bridge: randomized and directed transactions checked against a timeline model
module tb_d_sram_bridge;
   logic        clk = 1'b0, rst = 1'b0;
   logic        data_sram_en = 1'b0;
   logic [3:0]  data_sram_wen = 4'b0;
   logic [31:0] data_sram_addr = '0, data_sram_wdata = '0;
   logic [31:0] data_sram_rdata;
   logic        longest_stall = 1'b0, d_stall, data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
   logic [31:0] data_rdata = '0;

   int          nCmp = 0, nBad = 0, stallCnt = 0, reqCnt = 0;
   logic        chkOn = 1'b0, expReq = 1'b0, expStall = 1'b0, expWr = 1'b0;
   logic [1:0]  expSize = '0;
   logic [31:0] expAddr = '0, expWdata = '0, expRdata = '0;
   logic [3:0]  wens [9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } hs_t;
   hs_t hs[$];

   d_sram_bridge #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata), .longest_stall(longest_stall), .d_stall(d_stall),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] sizeOf(input logic [3:0] wen);
      if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
      if ($countones(wen) == 1) return 2'd0;
      return 2'd2;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkHs(input int i, input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      if (hs.size() <= i) begin
         nCmp++;
         nBad++;
         $display("FAIL hs%0d: handshake missing, got %0d handshakes expected at least %0d", i, hs.size(), i + 1);
      end else begin
         check("hs_wr", 32'(hs[i].wr), 32'(wr));
         check("hs_size", 32'(hs[i].size), 32'(sz));
         check("hs_addr", hs[i].addr, a);
         check("hs_wdata", hs[i].wdata, d);
      end
   endtask

   always @(negedge clk) begin
      if (chkOn) begin
         check("d_stall", 32'(d_stall), 32'(expStall));
         check("data_req", 32'(data_req), 32'(expReq));
         check("sram_rdata", data_sram_rdata, expRdata);
         if (expReq) begin
            check("data_addr", data_addr, expAddr);
            check("data_size", 32'(data_size), 32'(expSize));
            check("data_wr", 32'(data_wr), 32'(expWr));
            check("data_wdata", data_wdata, expWdata);
         end
         if (d_stall) stallCnt++;
         if (data_req) reqCnt++;
         if (data_req && data_addr_ok) begin
            hs_t e;
            e.wr = data_wr;
            e.size = data_size;
            e.addr = data_addr;
            e.wdata = data_wdata;
            hs.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearCounts();
      stallCnt = 0;
      reqCnt = 0;
      hs.delete();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         data_sram_en = 1'b0;
         data_sram_wen = 4'b0;
         data_addr_ok = 1'($urandom);
         data_data_ok = 1'($urandom);
         data_rdata = $urandom;
         longest_stall = 1'($urandom);
         expReq = 1'b0;
         expStall = 1'b0;
         step();
      end
   endtask

   // One access: addr_ok arrives aDly cycles after en, data_ok dDly cycles after that,
   // then the pipeline stays frozen for hold cycles.
   task automatic xact(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rd, input int aDly, input int dDly, input int hold);
      data_sram_en = 1'b1;
      data_sram_wen = wen;
      data_sram_addr = addr;
      data_sram_wdata = wdata;
      expWr = |wen;
      expSize = sizeOf(wen);
      expAddr = expWr ? addr : (addr & 32'hFFFF_FFFC);
      expWdata = wdata;
      for (int t = 0; t <= aDly + dDly; t++) begin
         data_addr_ok = (t == aDly);
         data_data_ok = (t == aDly + dDly);
         data_rdata = data_data_ok ? rd : $urandom;
         longest_stall = 1'($urandom);
         expReq = (t <= aDly);
         expStall = 1'b1;
         step();
      end
      expRdata = rd;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      expReq = 1'b0;
      expStall = 1'b0;
      for (int h = 0; h < hold; h++) begin
         longest_stall = 1'b1;
         data_rdata = $urandom;
         step();
      end
      longest_stall = 1'b0;
      step();
      data_sram_en = 1'b0;
   endtask

   initial begin
      step();
      step();
      rst = 1'b1;
      expRdata = '0;
      chkOn = 1'b1;
      check("reset_rdata", data_sram_rdata, 32'h0);
      idle(2);

      clearCounts();
      xact(4'b0000, 32'h0000_1006, 32'h0, 32'hDEAD_BEEF, 1, 3, 0);
      check("read_stall_cycles", 32'(stallCnt), 32'd5);
      check("read_hs_count", 32'(hs.size()), 32'd1);
      checkHs(0, 1'b0, 2'd2, 32'h0000_1004, 32'h0);
      check("read_rdata", data_sram_rdata, 32'hDEAD_BEEF);
      idle(1);

      clearCounts();
      xact(4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h1111_2222, 0, 1, 0);
      checkHs(0, 1'b1, 2'd0, 32'h0000_2002, 32'h00AB_0000);
      clearCounts();
      xact(4'b1100, 32'h0000_2002, 32'hCAFE_0000, 32'h3333_4444, 1, 0, 0);
      checkHs(0, 1'b1, 2'd1, 32'h0000_2002, 32'hCAFE_0000);
      idle(1);

      clearCounts();
      xact(4'b0000, 32'h0000_4000, 32'h0, 32'h1234_5678, 0, 0, 0);
      check("fast_stall_cycles", 32'(stallCnt), 32'd1);
      check("fast_req_cycles", 32'(reqCnt), 32'd1);
      check("fast_rdata", data_sram_rdata, 32'h1234_5678);

      clearCounts();
      xact(4'b0000, 32'h0000_5000, 32'h0, 32'h5A5A_A5A5, 1, 1, 3);
      check("hold_stall_cycles", 32'(stallCnt), 32'd3);
      check("hold_req_cycles", 32'(reqCnt), 32'd2);
      check("hold_hs_count", 32'(hs.size()), 32'd1);
      idle(1);

      // Reset while waiting for data, then a stale data_ok after release.
      data_sram_en = 1'b1;
      data_sram_wen = 4'b0000;
      data_sram_addr = 32'h0000_3000;
      data_sram_wdata = 32'h0;
      expAddr = 32'h0000_3000;
      expSize = 2'd2;
      expWr = 1'b0;
      expWdata = 32'h0;
      data_addr_ok = 1'b1;
      data_data_ok = 1'b0;
      expReq = 1'b1;
      expStall = 1'b1;
      step();
      data_addr_ok = 1'b0;
      expReq = 1'b0;
      step();
      step();
      chkOn = 1'b0;
      #2;
      rst = 1'b0;
      data_sram_en = 1'b0;
      #1;
      check("async_rdata", data_sram_rdata, 32'h0);
      check("async_req", 32'(data_req), 32'h0);
      check("async_stall", 32'(d_stall), 32'h0);
      step();
      step();
      rst = 1'b1;
      expRdata = '0;
      expStall = 1'b0;
      expReq = 1'b0;
      data_data_ok = 1'b1;
      data_rdata = 32'hBAD0_BAD0;
      chkOn = 1'b1;
      step();
      data_data_ok = 1'b0;
      check("late_ok_rdata", data_sram_rdata, 32'h0);
      xact(4'b1111, 32'h0000_6000, 32'h0F0F_0F0F, 32'h7777_8888, 2, 1, 0);
      check("post_reset_rdata", data_sram_rdata, 32'h7777_8888);

      clearCounts();
      xact(4'b0000, 32'h0000_7003, 32'h0, 32'hAAAA_0001, 0, 0, 0);
      xact(4'b1111, 32'h0000_7008, 32'h5555_0002, 32'hAAAA_0002, 0, 2, 0);
      check("b2b_hs_count", 32'(hs.size()), 32'd2);
      checkHs(0, 1'b0, 2'd2, 32'h0000_7000, 32'h0);
      checkHs(1, 1'b1, 2'd2, 32'h0000_7008, 32'h5555_0002);
      idle(1);

      for (int n = 0; n < 60; n++) begin
         logic [3:0] w;
         w = wens[$urandom_range(8)];
         xact(w, $urandom, $urandom, $urandom, $urandom_range(3), $urandom_range(3), $urandom_range(3));
         idle($urandom_range(2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
